// File: rtl/rgb_pwm_pkg.sv
// Shared types and helpers for the RGB LED PWM controller.
// Holds the driver-sequencing state encoding and the channel-index width rule.
package rgb_pwm_pkg;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_SETTLE,
        ST_ON,
        ST_DRAIN
    } state_t;

    // Channel index needs at least one bit even for a single channel
    function automatic int ch_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/rgb_pwm_ctrl_if.sv
// Configuration write channel of the RGB LED PWM controller.
// The master issues duty/fade writes and the slave accepts them with cfg_ready.
interface rgb_pwm_ctrl_if #(
    parameter int NCH   = 3,
    parameter int PWM_W = 8
) ();
    localparam int CH_W = rgb_pwm_pkg::ch_width(NCH);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [PWM_W-1:0] cfg_duty;
    logic             cfg_fade;

    modport master (
        output cfg_valid, cfg_ch, cfg_duty, cfg_fade,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_duty, cfg_fade,
        output cfg_ready
    );
endinterface

// File: rtl/rgb_pwm_chan.sv
// One PWM channel: target/current duty, jump-or-fade stepping at period
// boundaries and the registered compare that drives the LED pin.
module rgb_pwm_chan #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             run,
    input  logic [PWM_W-1:0] cnt,
    input  logic             period_end,
    input  logic             wr,
    input  logic [PWM_W-1:0] duty_in,
    input  logic             fade_in,
    output logic             pwm,
    output logic             busy
);
    logic [PWM_W-1:0] duty_tgt_reg;
    logic [PWM_W-1:0] duty_cur_reg;
    logic [PWM_W-1:0] duty_cur_next;
    logic             fade_reg;
    logic             pwm_reg;

    always_comb begin
        duty_cur_next = duty_cur_reg;
        if (!fade_reg) begin
            duty_cur_next = duty_tgt_reg;
        end else if (duty_cur_reg < duty_tgt_reg) begin
            duty_cur_next = duty_cur_reg + 1'b1;
        end else if (duty_cur_reg > duty_tgt_reg) begin
            duty_cur_next = duty_cur_reg - 1'b1;
        end
    end

    // duty_cur only moves on period_end so a period never sees two duties
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            duty_tgt_reg <= '0;
            duty_cur_reg <= '0;
            fade_reg     <= 1'b0;
            pwm_reg      <= 1'b0;
        end else begin
            if (wr) begin
                duty_tgt_reg <= duty_in;
                fade_reg     <= fade_in;
            end
            if (period_end) begin
                duty_cur_reg <= duty_cur_next;
            end
            pwm_reg <= run && (cnt < duty_cur_reg);
        end
    end

    assign pwm  = pwm_reg;
    assign busy = (duty_cur_reg != duty_tgt_reg);

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// Multi-channel PWM LED controller for the SB_RGBA_DRV path: timebase,
// driver enable sequencing (CURREN, settle, RGBLEDEN, drain) and config decode.
module rgb_pwm_ctrl
    import rgb_pwm_pkg::*;
#(
    parameter int NCH        = 3,
    parameter int PWM_W      = 8,
    parameter int PRESCALE   = 4,
    parameter int SETTLE_CYC = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    rgb_pwm_ctrl_if.slave    cfg,
    output logic             curren,
    output logic             rgbleden,
    output logic [NCH-1:0]   pwm,
    output logic [NCH-1:0]   busy,
    output logic             period_end
);
    localparam int CH_W = ch_width(NCH);
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_t           state_reg, state_next;
    logic [SC_W-1:0]  settle_reg, settle_next;
    logic [PS_W-1:0]  presc_reg;
    logic [PWM_W-1:0] cnt_reg;
    logic             curren_reg, rgbleden_reg;
    logic             run, tick, wr;

    assign run        = (state_reg == ST_ON) || (state_reg == ST_DRAIN);
    assign tick       = run && (presc_reg == PS_W'(PRESCALE - 1));
    assign period_end = tick && (cnt_reg == {PWM_W{1'b1}});

    assign cfg.cfg_ready = resetn;
    assign wr            = cfg.cfg_valid && cfg.cfg_ready;

    always_comb begin
        state_next  = state_reg;
        settle_next = settle_reg;
        case (state_reg)
            ST_OFF: begin
                if (enable) begin
                    state_next  = ST_SETTLE;
                    settle_next = SC_W'(SETTLE_CYC - 1);
                end
            end
            ST_SETTLE: begin
                if (!enable) begin
                    state_next = ST_OFF;
                end else if (settle_reg == '0) begin
                    state_next = ST_ON;
                end else begin
                    settle_next = settle_reg - 1'b1;
                end
            end
            ST_ON: begin
                if (!enable) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A re-enable wins over the period boundary so the LED keeps running
                if (enable) begin
                    state_next = ST_ON;
                end else if (period_end) begin
                    state_next = ST_OFF;
                end
            end
            default: state_next = ST_OFF;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= ST_OFF;
            settle_reg   <= '0;
            presc_reg    <= '0;
            cnt_reg      <= '0;
            curren_reg   <= 1'b0;
            rgbleden_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            settle_reg   <= settle_next;
            curren_reg   <= (state_next != ST_OFF);
            rgbleden_reg <= (state_next == ST_ON) || (state_next == ST_DRAIN);
            if (!run || tick) begin
                presc_reg <= '0;
            end else begin
                presc_reg <= presc_reg + 1'b1;
            end
            if (!run) begin
                cnt_reg <= '0;
            end else if (tick) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign curren   = curren_reg;
    assign rgbleden = rgbleden_reg;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        rgb_pwm_chan #(
            .PWM_W (PWM_W)
        ) u_chan (
            .clk        (clk),
            .resetn     (resetn),
            .run        (run),
            .cnt        (cnt_reg),
            .period_end (period_end),
            .wr         (wr && (cfg.cfg_ch == CH_W'(gi))),
            .duty_in    (cfg.cfg_duty),
            .fade_in    (cfg.cfg_fade),
            .pwm        (pwm[gi]),
            .busy       (busy[gi])
        );
    end

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Directed self-checking bench for rgb_pwm_ctrl: table of jump writes plus
// hand sequences for fade, boundary writes, shutdown and async reset.
module tb_rgb_pwm_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn_a, enable_a, curren_a, rgbleden_a, period_end_a;
    logic [2:0] pwm_a, busy_a;
    logic       resetn_b, enable_b, curren_b, rgbleden_b, period_end_b;
    logic [2:0] pwm_b, busy_b;

    rgb_pwm_ctrl_if #(.NCH(3), .PWM_W(4)) cfg_a ();
    rgb_pwm_ctrl_if #(.NCH(3), .PWM_W(4)) cfg_b ();

    rgb_pwm_ctrl #(.NCH(3), .PWM_W(4), .PRESCALE(1), .SETTLE_CYC(3)) dut_a (
        .clk        (clk),
        .resetn     (resetn_a),
        .enable     (enable_a),
        .cfg        (cfg_a),
        .curren     (curren_a),
        .rgbleden   (rgbleden_a),
        .pwm        (pwm_a),
        .busy       (busy_a),
        .period_end (period_end_a)
    );

    rgb_pwm_ctrl #(.NCH(3), .PWM_W(4), .PRESCALE(4), .SETTLE_CYC(3)) dut_b (
        .clk        (clk),
        .resetn     (resetn_b),
        .enable     (enable_b),
        .cfg        (cfg_b),
        .curren     (curren_b),
        .rgbleden   (rgbleden_b),
        .pwm        (pwm_b),
        .busy       (busy_b),
        .period_end (period_end_b)
    );

    typedef struct {
        logic [1:0] ch;
        logic [3:0] duty;
        int         exp_hi;
    } vec_t;

    vec_t tbl[4];
    int   n_cmp = 0;
    int   n_err = 0;
    int   meas[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("check %s: %0d ok", name, act);
        end
    endtask

    task automatic write_a(input logic [1:0] ch, input logic [3:0] duty, input logic fade);
        cfg_a.cfg_ch    = ch;
        cfg_a.cfg_duty  = duty;
        cfg_a.cfg_fade  = fade;
        cfg_a.cfg_valid = 1'b1;
        @(negedge clk);
        cfg_a.cfg_valid = 1'b0;
    endtask

    task automatic write_b(input logic [1:0] ch, input logic [3:0] duty, input logic fade);
        cfg_b.cfg_ch    = ch;
        cfg_b.cfg_duty  = duty;
        cfg_b.cfg_fade  = fade;
        cfg_b.cfg_valid = 1'b1;
        @(negedge clk);
        cfg_b.cfg_valid = 1'b0;
    endtask

    task automatic wait_pe_a();
        int k = 0;
        while (period_end_a !== 1'b1 && k < 64) begin
            @(negedge clk);
            k++;
        end
        if (period_end_a !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL pe_timeout: got 0, expected period_end within 64 cycles");
        end
    endtask

    // Called on a period_end cycle; counts pwm high cycles over the next n periods
    task automatic measure_a(input int ch, input int n);
        @(negedge clk);
        cfg_a.cfg_valid = 1'b0;
        for (int p = 0; p < n; p++) begin
            meas[p] = 0;
            repeat (16) begin
                @(negedge clk);
                if (pwm_a[ch]) meas[p]++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit flag;
        tbl[0] = '{ch: 2'd0, duty: 4'd5,  exp_hi: 5};
        tbl[1] = '{ch: 2'd0, duty: 4'd0,  exp_hi: 0};
        tbl[2] = '{ch: 2'd0, duty: 4'd15, exp_hi: 15};
        tbl[3] = '{ch: 2'd2, duty: 4'd4,  exp_hi: 4};

        resetn_a = 1'b0; enable_a = 1'b0;
        resetn_b = 1'b0; enable_b = 1'b0;
        cfg_a.cfg_valid = 1'b0; cfg_a.cfg_ch = '0; cfg_a.cfg_duty = '0; cfg_a.cfg_fade = 1'b0;
        cfg_b.cfg_valid = 1'b0; cfg_b.cfg_ch = '0; cfg_b.cfg_duty = '0; cfg_b.cfg_fade = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_curren", curren_a, 0);
        check("rst_rgbleden", rgbleden_a, 0);
        check("rst_pwm", pwm_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_period_end", period_end_a, 0);
        resetn_a = 1'b1;
        resetn_b = 1'b1;
        @(negedge clk);
        check("cfg_ready", cfg_a.cfg_ready, 1);

        // Power-up: enable at cycle 0
        enable_a = 1'b1;
        check("pu_c0_curren", curren_a, 0);
        @(negedge clk);
        check("pu_c1_curren", curren_a, 1);
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) @(negedge clk);
            check($sformatf("pu_c%0d_rgbleden", c), rgbleden_a, 0);
            check($sformatf("pu_c%0d_pwm", c), pwm_a, 0);
        end
        @(negedge clk);
        check("pu_c4_rgbleden", rgbleden_a, 1);

        // Jump writes from the table
        for (int i = 0; i < 4; i++) begin
            write_a(tbl[i].ch, tbl[i].duty, 1'b0);
            wait_pe_a();
            measure_a(int'(tbl[i].ch), 1);
            check($sformatf("jump%0d_high", i), meas[0], tbl[i].exp_hi);
            check($sformatf("jump%0d_busy", i), busy_a[tbl[i].ch], 0);
        end

        // Fade up 0 -> 3, then down 3 -> 0
        write_a(2'd1, 4'd3, 1'b1);
        check("fade_up_busy", busy_a[1], 1);
        wait_pe_a();
        measure_a(1, 3);
        check("fade_up_p1", meas[0], 1);
        check("fade_up_p2", meas[1], 2);
        check("fade_up_p3", meas[2], 3);
        check("fade_up_done_busy", busy_a[1], 0);
        write_a(2'd1, 4'd0, 1'b1);
        check("fade_dn_busy", busy_a[1], 1);
        wait_pe_a();
        measure_a(1, 3);
        check("fade_dn_p1", meas[0], 2);
        check("fade_dn_p2", meas[1], 1);
        check("fade_dn_p3", meas[2], 0);

        // Write landing on the period_end cycle
        wait_pe_a();
        cfg_a.cfg_ch    = 2'd2;
        cfg_a.cfg_duty  = 4'd8;
        cfg_a.cfg_fade  = 1'b0;
        cfg_a.cfg_valid = 1'b1;
        measure_a(2, 2);
        check("coinc_p1_old", meas[0], 4);
        check("coinc_p2_new", meas[1], 8);

        // Brief drain aborted by re-enable keeps the LED on
        enable_a = 1'b0;
        repeat (3) @(negedge clk);
        enable_a = 1'b1;
        wait_pe_a();
        @(negedge clk);
        check("reen_curren", curren_a, 1);
        check("reen_rgbleden", rgbleden_a, 1);

        // Orderly shutdown mid-period
        repeat (3) @(negedge clk);
        enable_a = 1'b0;
        wait_pe_a();
        check("drain_pe_rgbleden", rgbleden_a, 1);
        check("drain_pe_pwm0", pwm_a[0], 1);
        @(negedge clk);
        check("off_curren", curren_a, 0);
        check("off_rgbleden", rgbleden_a, 0);
        check("off_pwm", pwm_a, 0);

        // Abort during settle
        enable_a = 1'b1;
        @(negedge clk);
        check("abort_curren_on", curren_a, 1);
        check("abort_rgbleden", rgbleden_a, 0);
        enable_a = 1'b0;
        @(negedge clk);
        check("abort_curren_off", curren_a, 0);
        flag = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rgbleden_a) flag = 1'b1;
        end
        check("abort_rgbleden_never", flag, 0);

        // Async reset mid-ON on the prescaled instance
        enable_b = 1'b1;
        repeat (4) @(negedge clk);
        check("b_on_rgbleden", rgbleden_b, 1);
        write_b(2'd0, 4'd8, 1'b0);
        write_b(2'd1, 4'd10, 1'b1);
        repeat (100) @(negedge clk);
        check("b_pre_busy1", busy_b[1], 1);
        flag = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (pwm_b[0]) flag = 1'b1;
        end
        check("b_pre_pwm0_seen", flag, 1);
        #2;
        resetn_b = 1'b0;
        enable_b = 1'b0;
        #1;
        check("b_rst_curren", curren_b, 0);
        check("b_rst_rgbleden", rgbleden_b, 0);
        check("b_rst_pwm", pwm_b, 0);
        check("b_rst_busy", busy_b, 0);
        check("b_rst_period_end", period_end_b, 0);
        @(negedge clk);
        resetn_b = 1'b1;
        @(negedge clk);
        enable_b = 1'b1;
        check("b_re_c0_curren", curren_b, 0);
        @(negedge clk);
        check("b_re_c1_curren", curren_b, 1);
        check("b_re_c1_rgbleden", rgbleden_b, 0);
        repeat (2) @(negedge clk);
        check("b_re_c3_rgbleden", rgbleden_b, 0);
        @(negedge clk);
        check("b_re_c4_rgbleden", rgbleden_b, 1);
        write_b(2'd3, 4'd9, 1'b0);
        check("b_ch3_busy", busy_b, 0);
        flag = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (pwm_b != 3'b000 || busy_b != 3'b000) flag = 1'b1;
        end
        check("b_cleared_and_ch3_ignored", flag, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
